mem_bus_master: RTL

- Initiator side of the single-port shared-bus data memory: the memory responds with combinational read and posedge write on a tri-state Data bus.
- Accepts read/write requests from the CPU datapath over a valid/ready handshake.
- Sequences the memory's re/we/Address/Data lines and returns read data as registered response beats.
- Supports single-word writes and incrementing read bursts of up to 2**LENW words, e.g. for instruction/operand fetch.

---
 rtl/mem_bus_master.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - initiator for the shared-bus data memory: single writes, incrementing read bursts
// Optional MEM_BUS_MASTER_BOUNDARY_EN: stop bursts at the top address and flag it on burst_err
module mem_bus_master #(
   parameter int DW   = 8,
   parameter int AW   = 8,
   parameter int LENW = 2
) (
   input  logic            clock,
   input  logic            reset_L,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [LENW-1:0] req_len,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_data,
   output logic            rsp_last,
   output logic            wr_done,
   output logic            busy,
   output logic            mem_re,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
`ifdef MEM_BUS_MASTER_BOUNDARY_EN
   output logic            burst_err,
`endif
   inout  wire  [DW-1:0]   mem_data
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   state_t          r_state;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic [LENW-1:0] r_len;
   logic [LENW-1:0] r_beat;
   logic            r_re;
   logic            r_we;
   logic            r_rsp_valid;
   logic [DW-1:0]   r_rsp_data;
   logic            r_rsp_last;
   logic            r_wr_done;
   logic            w_beat_last;
   logic            w_end;

   assign w_beat_last = (r_beat == r_len);

`ifdef MEM_BUS_MASTER_BOUNDARY_EN
   logic r_burst_err;
   logic w_top;
   assign w_top     = &r_addr;
   assign w_end     = w_beat_last | w_top;
   assign burst_err = r_burst_err;
`else
   assign w_end     = w_beat_last;
`endif

   // Bus is only ever driven during the single WRITE cycle
   assign mem_data  = r_we ? r_wdata : {DW{1'bz}};
   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign mem_re    = r_re;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_last  = r_rsp_last;
   assign wr_done   = r_wr_done;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_len       <= '0;
         r_beat      <= '0;
         r_re        <= 1'b0;
         r_we        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_last  <= 1'b0;
         r_wr_done   <= 1'b0;
`ifdef MEM_BUS_MASTER_BOUNDARY_EN
         r_burst_err <= 1'b0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_wr_done   <= 1'b0;
`ifdef MEM_BUS_MASTER_BOUNDARY_EN
         r_burst_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_len   <= req_len;
                  r_beat  <= '0;
                  if (req_write) begin
                     r_we    <= 1'b1;
                     r_state <= S_WRITE;
                  end else begin
                     r_re    <= 1'b1;
                     r_state <= S_READ;
                  end
               end
            end
            S_READ: begin
               r_rsp_data  <= mem_data;
               r_rsp_valid <= 1'b1;
               r_rsp_last  <= w_end;
`ifdef MEM_BUS_MASTER_BOUNDARY_EN
               r_burst_err <= w_top & ~w_beat_last;
`endif
               if (w_end) begin
                  r_re    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_addr <= r_addr + 1'b1;
                  r_beat <= r_beat + 1'b1;
               end
            end
            S_WRITE: begin
               r_we      <= 1'b0;
               r_wr_done <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
